c17_resp_misr: RTL and testbench
================================

Name: c17_resp_misr

Overview:
- Output-response compactor sitting directly downstream of the C17 benchmark netlist in the BIST chain.
- Each cycle that `resp_valid` is high, it absorbs the two circuit outputs (G6gat, G7gat) into a multiple-input signature register (MISR) for a programmed number of patterns.
- When the run finishes, it raises `done` and compares the final signature against a golden value, producing pass/fail for fault-injection campaigns.

Parameters:
- MISR_W, 16, signature width (≥ 4).
- TAPS, 16'hB400, feedback tap mask: x^16+x^14+x^13+x^11+1, Fibonacci form.
- CNT_W, 8, width of the pattern counter and of `num_patterns`.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  1-cycle pulse; begins a run (ignored unless in IDLE or DONE).
- num_patterns  in  CNT_W  patterns to absorb; sampled on accepted `start`.
- resp_valid  in  1  `resp` holds a valid circuit response this cycle.
- resp  in  2  {G6gat, G7gat}; resp[1]=G6gat, resp[0]=G7gat.
- golden_sig  in  MISR_W  expected signature; sampled when entering DONE.
- busy  out  1  high in RUN.
- done  out  1  high in DONE, held until next `start` or `rst`.
- pass  out  1  valid while `done`; 1 iff signature == golden_sig.
- signature  out  MISR_W  current MISR contents.
- count  out  CNT_W  responses absorbed in the current run.

Behaviour:
- Clock/reset: one clock, `clk`; reset `rst` is synchronous, active-high.
- Reset: state=IDLE, signature=0, count=0, busy=0, done=0, pass=0. `rst` mid-run aborts immediately with no partial `done`.
- MISR update (RUN and resp_valid only):
  - fb = XOR-reduce(signature & TAPS).
  - next = {signature[MISR_W-2:0], fb} XOR {0…0, resp[1], resp[0]}.
- FSM states:
  - IDLE: start -> RUN; signature<=0, count<=0, latch num_patterns.
  - RUN: on each resp_valid, update MISR and count<=count+1. When the absorbing beat makes count == latched num_patterns, go to DONE the next cycle. `resp_valid` low: hold everything.
  - DONE: done=1; pass registered on entry (1-cycle latency after the last beat). start -> RUN with signature and count cleared; resp_valid ignored.
- num_patterns=0: start goes directly IDLE->DONE; signature=0, pass=(golden_sig==0).
- start while in RUN is ignored. start and resp_valid in the same cycle in IDLE/DONE: the response is not absorbed.
- count never wraps: maximum run is 2^CNT_W-1 patterns.
- Latency: signature reflects a beat one cycle after that beat; done/pass assert one cycle after the final beat's update.

Optional Feature:
- Macro C17_MISR_XMASK_EN.
- When defined:
  - Adds input `xmask [1:0]`; resp bits with xmask=1 are forced to 0 before XOR, for unknown/X-generating fault sites.
  - Adds output `masked_cnt [CNT_W-1:0]`: counts beats with any mask bit set; clears on start.
- When undefined: no extra ports; behaviour exactly as above.

Decomposition:
- Package c17_bist_pkg holds:
  - state enum {ST_IDLE, ST_RUN, ST_DONE};
  - default MISR_W/TAPS/CNT_W constants;
  - RESP_W=2, so the upstream pattern generator and this block agree.
- One natural sub-module: misr_core (purely the shift/feedback register with enable/clear), reused by other benchmark compactors. FSM and counter stay in the top.

Test Plan:
- rst, start with num_patterns=3, resp 01,00,00 on 3 valid beats -> signature 0x0004, count=3, done=1, pass=1 with golden 0x0004.
- Single pattern resp=11 -> signature 0x0003; golden 0x0002 -> pass=0.
- Wrap feedback: load via 16 beats so signature=0x8000, then resp=00 -> 0x0001 (fb from bit15).
- num_patterns=0 -> done next cycle, signature 0x0000, pass=1 with golden 0.
- Gaps: 3 patterns with resp_valid toggling 1,0,0,1,1 -> same signature as a contiguous run; start during RUN ignored; rst asserted mid-run -> all outputs 0 next cycle.
- With C17_MISR_XMASK_EN: resp=11, xmask=10 -> signature 0x0001, masked_cnt=1.

Source files
------------

// File: rtl/c17_bist_pkg.sv
// Shared types and defaults for the C17 BIST chain.
// Pattern generator and response compactor agree on RESP_W here.
package c17_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int          MISR_W_DEF = 16;
    localparam logic [15:0] TAPS_DEF   = 16'hB400;
    localparam int          CNT_W_DEF  = 8;
    localparam int          RESP_W     = 2;

endpackage

// File: rtl/misr_core.sv
// Fibonacci multiple-input signature register with clear and enable.
// Parallel inputs fold into the low bits after the shift.
module misr_core
    import c17_bist_pkg::*;
#(
    parameter int              W    = MISR_W_DEF,
    parameter logic [W-1:0]    TAPS = W'(TAPS_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [RESP_W-1:0] din,
    output logic [W-1:0]      sig
);

    logic         fb;
    logic [W-1:0] sig_nxt;

    always_comb begin
        fb      = ^(sig & TAPS);
        sig_nxt = {sig[W-2:0], fb} ^ {{(W-RESP_W){1'b0}}, din};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= sig_nxt;
        end
    end

endmodule

// File: rtl/c17_resp_misr.sv
// C17 output-response compactor: MISR run control, count and pass/fail.
// Define C17_MISR_XMASK_EN to add per-bit response masking and masked_cnt.
module c17_resp_misr
    import c17_bist_pkg::*;
#(
    parameter int                MISR_W = MISR_W_DEF,
    parameter logic [MISR_W-1:0] TAPS   = MISR_W'(TAPS_DEF),
    parameter int                CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_patterns,
    input  logic              resp_valid,
    input  logic [1:0]        resp,
    input  logic [MISR_W-1:0] golden_sig,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature,
    output logic [CNT_W-1:0]  count
`ifdef C17_MISR_XMASK_EN
    ,
    input  logic [1:0]        xmask,
    output logic [CNT_W-1:0]  masked_cnt
`endif
);

    state_t            state, state_d;
    logic [CNT_W-1:0]  npat;
    logic              go;
    logic              absorb;
    logic              enter_done;
    logic [RESP_W-1:0] resp_eff;

`ifdef C17_MISR_XMASK_EN
    assign resp_eff = resp & ~xmask;
`else
    assign resp_eff = resp;
`endif

    always_comb begin
        state_d    = state;
        go         = 1'b0;
        absorb     = 1'b0;
        enter_done = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    go      = 1'b1;
                    state_d = (num_patterns == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (count == npat) begin
                    state_d = ST_DONE;
                end else if (resp_valid) begin
                    absorb = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        enter_done = (state_d == ST_DONE) && ((state != ST_DONE) || go);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            npat  <= '0;
            count <= '0;
            pass  <= 1'b0;
        end else begin
            state <= state_d;
            if (go) begin
                npat  <= num_patterns;
                count <= '0;
            end else if (absorb) begin
                count <= count + 1'b1;
            end
            // A zero-length run compares the freshly cleared signature.
            if (go) begin
                pass <= enter_done && (golden_sig == '0);
            end else if (enter_done) begin
                pass <= (signature == golden_sig);
            end
        end
    end

`ifdef C17_MISR_XMASK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            masked_cnt <= '0;
        end else if (go) begin
            masked_cnt <= '0;
        end else if (absorb && (|xmask)) begin
            masked_cnt <= masked_cnt + 1'b1;
        end
    end
`endif

    misr_core #(
        .W    (MISR_W),
        .TAPS (TAPS)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (go),
        .en  (absorb),
        .din (resp_eff),
        .sig (signature)
    );

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_c17_resp_misr.sv
// Directed bench for c17_resp_misr with hand-computed signatures.
// Build with C17_MISR_XMASK_EN to also cover response masking.
module tb_c17_resp_misr;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  num_patterns;
    logic        resp_valid;
    logic [1:0]  resp;
    logic [15:0] golden_sig;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;
    logic [7:0]  count;
`ifdef C17_MISR_XMASK_EN
    logic [1:0]  xmask;
    logic [7:0]  masked_cnt;
`endif

    int checks;
    int errors;

    c17_resp_misr dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_patterns (num_patterns),
        .resp_valid   (resp_valid),
        .resp         (resp),
        .golden_sig   (golden_sig),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .signature    (signature),
        .count        (count)
`ifdef C17_MISR_XMASK_EN
        ,
        .xmask        (xmask),
        .masked_cnt   (masked_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_run(input logic [7:0] n, input logic [15:0] g);
        start        = 1'b1;
        num_patterns = n;
        golden_sig   = g;
        step();
        start = 1'b0;
    endtask

    task automatic beat(input logic [1:0] r);
        resp_valid = 1'b1;
        resp       = r;
        step();
        resp_valid = 1'b0;
        resp       = 2'b00;
    endtask

    // Beats 1..16 walk a single one up to bit 15, cancelling each tap hit.
    logic [1:0] wrap_tbl [16] = '{
        2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
        2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00
    };

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        start        = 1'b0;
        num_patterns = '0;
        resp_valid   = 1'b0;
        resp         = 2'b00;
        golden_sig   = '0;
`ifdef C17_MISR_XMASK_EN
        xmask        = 2'b00;
`endif
        step();
        step();
        rst = 1'b0;
        chk("rst_sig", 32'(signature), 32'h0);
        chk("rst_cnt", 32'(count), 32'h0);
        chk("rst_flags", 32'({busy, done, pass}), 32'h0);

        go_run(8'd3, 16'h0004);
        chk("t1_busy", 32'(busy), 32'h1);
        beat(2'b01);
        chk("t1_lat", 32'(signature), 32'h0001);
        beat(2'b00);
        beat(2'b00);
        chk("t1_sig", 32'(signature), 32'h0004);
        chk("t1_cnt", 32'(count), 32'd3);
        chk("t1_notdone", 32'(done), 32'h0);
        step();
        chk("t1_done", 32'({busy, done, pass}), 32'b011);

        go_run(8'd1, 16'h0002);
        beat(2'b11);
        chk("t2_sig", 32'(signature), 32'h0003);
        step();
        chk("t2_flags", 32'({done, pass}), 32'b10);

        go_run(8'd17, 16'h0001);
        for (int i = 0; i < 16; i++) beat(wrap_tbl[i]);
        chk("t3_8000", 32'(signature), 32'h8000);
        beat(2'b00);
        chk("t3_wrap", 32'(signature), 32'h0001);
        step();
        chk("t3_done", 32'({done, pass}), 32'b11);
        chk("t3_cnt", 32'(count), 32'd17);

        go_run(8'd0, 16'h0000);
        chk("t4_flags", 32'({busy, done, pass}), 32'b011);
        chk("t4_sig", 32'(signature), 32'h0);
        go_run(8'd0, 16'h0005);
        chk("t4_fail", 32'({done, pass}), 32'b10);

        go_run(8'd3, 16'h0004);
        beat(2'b01);
        resp = 2'b11;
        step();
        start        = 1'b1;
        num_patterns = 8'd1;
        step();
        start = 1'b0;
        chk("t5_ignstart", 32'({busy, count}), {23'd0, 1'b1, 8'd1});
        beat(2'b00);
        beat(2'b00);
        step();
        chk("t5_sig", 32'(signature), 32'h0004);
        chk("t5_done", 32'({done, pass, count}), {22'd0, 2'b11, 8'd3});

        start        = 1'b1;
        num_patterns = 8'd2;
        resp_valid   = 1'b1;
        resp         = 2'b11;
        step();
        start      = 1'b0;
        resp_valid = 1'b0;
        chk("t6_noabs", 32'({busy, count, signature}), {7'd0, 1'b1, 8'd0, 16'h0});
        beat(2'b01);
        chk("t6_beat", 32'(signature), 32'h0001);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst", 32'({busy, done, pass, count, signature}), 32'h0);

`ifdef C17_MISR_XMASK_EN
        go_run(8'd1, 16'h0001);
        xmask = 2'b10;
        beat(2'b11);
        xmask = 2'b00;
        chk("t7_sig", 32'(signature), 32'h0001);
        chk("t7_mcnt", 32'(masked_cnt), 32'd1);
        step();
        chk("t7_pass", 32'({done, pass}), 32'b11);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
